// File: rtl/operand_fifo.sv
`default_nettype none
// ============================================================================
// Module      : operand_fifo
// Description : First-word-fall-through FIFO of {multiplicand, multiplier}
//               operand pairs feeding a multiplier control unit.
//               Circular buffer with separate read/write pointers, an
//               occupancy counter, combinational empty/full, and sticky
//               overflow/underflow error flags cleared only by reset.
//
// Ports       : clk              - single clock, rising edge
//               reset            - synchronous active-high reset
//               wr_en            - push one operand pair
//               wr_multiplicand  - multiplicand word to push
//               wr_multiplier    - multiplier word to push
//               load_words       - pop the head pair (consumer captures it
//                                  on the same edge)
//               flush            - discard all stored pairs
//               multiplicand_out - head multiplicand (0 while empty)
//               multiplier_out   - head multiplier   (0 while empty)
//               empty / full     - occupancy status decoded from count
//               count            - number of stored pairs, 0..DEPTH
//               overflow         - sticky, set by a rejected push
//               underflow        - sticky, set by a pop while empty
//
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fifo #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_multiplicand,
    input  logic [WORD_W-1:0] wr_multiplier,
    input  logic              load_words,
    input  logic              flush,
    output logic [WORD_W-1:0] multiplicand_out,
    output logic [WORD_W-1:0] multiplier_out,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] c_PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_FULL = DEPTH[ADDR_W:0];

    // Registered state
    logic [ADDR_W-1:0]   r_wr_ptr_q;
    logic [ADDR_W-1:0]   r_rd_ptr_q;
    logic [ADDR_W:0]     r_count_q;
    logic                r_overflow_q;
    logic                r_underflow_q;
    logic [2*WORD_W-1:0] r_mem_q [DEPTH];

    // Next-state and decode
    logic [ADDR_W-1:0]   w_wr_ptr_d;
    logic [ADDR_W-1:0]   w_rd_ptr_d;
    logic [ADDR_W:0]     w_count_d;
    logic                w_overflow_d;
    logic                w_underflow_d;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic [2*WORD_W-1:0] w_head;

    assign w_empty = (r_count_q == '0);
    assign w_full  = (r_count_q == c_CNT_FULL);

    // A pop frees a slot on the same edge, so a push at full is still
    // accepted when paired with a pop.
    assign w_pop  = load_words & ~w_empty;
    assign w_push = wr_en & (~w_full | w_pop);

    always_comb begin
        w_wr_ptr_d    = r_wr_ptr_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_count_d     = r_count_q;
        // Flush neither sets nor clears the error flags; a push or pop that
        // coincides with a flush is discarded rather than judged.
        w_overflow_d  = r_overflow_q  | (wr_en & ~w_push & ~flush);
        w_underflow_d = r_underflow_q | (load_words & w_empty & ~flush);

        if (flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_d = r_count_q + c_CNT_ONE;
                2'b01:   w_count_d = r_count_q - c_CNT_ONE;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_count_q     <= '0;
            r_overflow_q  <= 1'b0;
            r_underflow_q <= 1'b0;
        end else begin
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_count_q     <= w_count_d;
            r_overflow_q  <= w_overflow_d;
            r_underflow_q <= w_underflow_d;
        end
    end

    // Storage is never cleared: its contents are masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_mem_q[r_wr_ptr_q] <= {wr_multiplicand, wr_multiplier};
        end
    end

    assign w_head = w_empty ? '0 : r_mem_q[r_rd_ptr_q];

    assign multiplicand_out = w_head[2*WORD_W-1:WORD_W];
    assign multiplier_out   = w_head[WORD_W-1:0];
    assign empty            = w_empty;
    assign full             = w_full;
    assign count            = r_count_q;
    assign overflow         = r_overflow_q;
    assign underflow        = r_underflow_q;

endmodule
`default_nettype wire
